// File: rtl/bip_control_unit_if.sv
// Sequencer-side bundle for the BIP core: PC load port, fetched instruction, datapath strobes and status.
// Combinational strobes qualified by state; no backpressure, the core consumes every strobe in the cycle it is issued.
interface bip_control_unit_if #(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int CW  = 32
);
    logic              start;
    logic [AB-1:0]     pc_addr;
    logic [OPW+AB-1:0] instr;
    logic              WrPC;
    logic [AB-1:0]     address_bus;
    logic [AB-1:0]     operand;
    logic [1:0]        SelA;
    logic              SelB;
    logic              Op;
    logic              WrAcc;
    logic              WrRam;
    logic              RdRam;
    logic              busy;
    logic              done;
    logic [CW-1:0]     clk_count;

    modport master (
        input  start, pc_addr, instr,
        output WrPC, address_bus, operand, SelA, SelB, Op,
               WrAcc, WrRam, RdRam, busy, done, clk_count
    );

    modport slave (
        output start, pc_addr, instr,
        input  WrPC, address_bus, operand, SelA, SelB, Op,
               WrAcc, WrRam, RdRam, busy, done, clk_count
    );
endinterface

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: two-cycle fetch/execute loop, every instruction takes exactly 2 cycles.
// Strobes are combinational from state and IR; no backpressure, start is only sampled in IDLE/HALT.
module bip_control_unit #(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int CW  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bip_control_unit_if.master    bus
);
    localparam int IW = OPW + AB;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
    localparam logic [OPW-1:0] OP_STO  = OPW'(1);
    localparam logic [OPW-1:0] OP_LD   = OPW'(2);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(7);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q;
    logic [CW-1:0]   cnt_q;
    logic [OPW-1:0]  opcode;
    logic            launch;
    logic            running;

    logic            wr_pc;
    logic [AB-1:0]   next_pc;
    logic [1:0]      sel_a;
    logic            sel_b;
    logic            alu_op;
    logic            wr_acc;
    logic            wr_ram;
    logic            rd_ram;

    assign opcode  = ir_q[IW-1 -: OPW];
    assign running = (state_q == FETCH) || (state_q == EXEC);
    assign launch  = ((state_q == IDLE) || (state_q == HALT)) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                ir_q <= bus.instr;
            end
            // Statistics counter saturates so long programs never appear short.
            if (launch) begin
                cnt_q <= '0;
            end else if (running && (cnt_q != {CW{1'b1}})) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wr_pc   = 1'b0;
        next_pc = '0;
        sel_a   = 2'b00;
        sel_b   = 1'b0;
        alu_op  = 1'b0;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    wr_pc   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                wr_pc   = 1'b1;
                next_pc = bus.pc_addr + AB'(1);
                case (opcode)
                    OP_HLT: begin
                        wr_pc   = 1'b0;
                        next_pc = '0;
                        state_d = HALT;
                    end
                    OP_STO: wr_ram = 1'b1;
                    OP_LD: begin
                        rd_ram = 1'b1;
                        wr_acc = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a  = 2'b01;
                        wr_acc = 1'b1;
                    end
                    OP_ADD: begin
                        rd_ram = 1'b1;
                        sel_a  = 2'b10;
                        wr_acc = 1'b1;
                    end
                    OP_ADDI: begin
                        sel_b  = 1'b1;
                        sel_a  = 2'b10;
                        wr_acc = 1'b1;
                    end
                    OP_SUB: begin
                        rd_ram = 1'b1;
                        alu_op = 1'b1;
                        sel_a  = 2'b10;
                        wr_acc = 1'b1;
                    end
                    OP_SUBI: begin
                        sel_b  = 1'b1;
                        alu_op = 1'b1;
                        sel_a  = 2'b10;
                        wr_acc = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.WrPC        = wr_pc;
    assign bus.address_bus = next_pc;
    assign bus.operand     = ir_q[AB-1:0];
    assign bus.SelA        = sel_a;
    assign bus.SelB        = sel_b;
    assign bus.Op          = alu_op;
    assign bus.WrAcc       = wr_acc;
    assign bus.WrRam       = wr_ram;
    assign bus.RdRam       = rd_ram;
    assign bus.busy        = running;
    assign bus.done        = (state_q == HALT);
    assign bus.clk_count   = cnt_q;
endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: an instruction-level program model fills a scoreboard; a negedge monitor compares.
module tb_bip_control_unit;
    localparam int AB  = 11;
    localparam int OPW = 5;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          wrpc;
        logic [AB-1:0] addr;
        logic [AB-1:0] operand;
        logic [1:0]    sela;
        logic          selb;
        logic          op;
        logic          wracc;
        logic          wrram;
        logic          rdram;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bip_control_unit_if #(.AB(AB), .OPW(OPW), .CW(CW)) bus ();

    bip_control_unit #(.AB(AB), .OPW(OPW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Program memory and program counter live in the bench as the surrounding core.
    logic [OPW+AB-1:0] mem [0:(1<<AB)-1];
    logic [AB-1:0]     pc           = '0;
    logic              pc_force     = 1'b0;
    logic [AB-1:0]     pc_force_val = '0;

    always @(posedge clk) begin
        if (pc_force) pc <= pc_force_val;
        else if (bus.WrPC) pc <= bus.address_bus;
    end

    assign bus.pc_addr = pc;
    assign bus.instr   = mem[pc];

    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic          m_done = 1'b0;
    logic [CW-1:0] m_cnt  = '0;
    logic [AB-1:0] m_opnd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t s;
        s.wrpc    = bus.WrPC;
        s.addr    = bus.address_bus;
        s.operand = bus.operand;
        s.sela    = bus.SelA;
        s.selb    = bus.SelB;
        s.op      = bus.Op;
        s.wracc   = bus.WrAcc;
        s.wrram   = bus.WrRam;
        s.rdram   = bus.RdRam;
        s.busy    = bus.busy;
        s.done    = bus.done;
        s.cnt     = bus.clk_count;
        return s;
    endfunction

    // Instruction classes: 4..7 are ALU ops; odd ALU ops take the immediate, the upper pair subtracts.
    function automatic out_t effects(input int opc);
        out_t e;
        bit   arith;
        e     = '0;
        arith = (opc >= 4) && (opc <= 7);
        if (opc == 1) e.wrram = 1'b1;
        if (opc == 2) begin e.rdram = 1'b1; e.wracc = 1'b1; e.sela = 2'd0; end
        if (opc == 3) begin e.sela = 2'd1; e.wracc = 1'b1; end
        if (arith) begin
            e.sela  = 2'd2;
            e.wracc = 1'b1;
            e.selb  = (opc % 2) == 1;
            e.rdram = (opc % 2) == 0;
            e.op    = opc >= 6;
        end
        return e;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic model_program(input logic [AB-1:0] entry, input int max_push, output int busy_cycles);
        out_t              e;
        int                pushed = 0;
        int                c = 0;
        int                n = 0;
        int                opc;
        logic [AB-1:0]     p = entry;
        logic [OPW+AB-1:0] w;
        e = '0; e.wrpc = 1'b1; e.operand = m_opnd; e.done = m_done; e.cnt = m_cnt;
        if (pushed < max_push) exp_q.push_back(e);
        pushed++;
        while (n < 4096) begin
            w = mem[p];
            opc = int'(w[OPW+AB-1 -: OPW]);
            e = '0; e.busy = 1'b1; e.operand = m_opnd; e.cnt = CW'(c);
            if (pushed < max_push) exp_q.push_back(e);
            pushed++;
            c = sat_inc(c);
            m_opnd = w[AB-1:0];
            e = effects(opc); e.busy = 1'b1; e.operand = m_opnd; e.cnt = CW'(c);
            if (opc != 0) begin e.wrpc = 1'b1; e.addr = p + AB'(1); end
            if (pushed < max_push) exp_q.push_back(e);
            pushed++;
            c = sat_inc(c);
            n++;
            if (opc == 0) break;
            p = p + AB'(1);
        end
        e = '0; e.done = 1'b1; e.operand = m_opnd; e.cnt = CW'(c);
        if (pushed < max_push) exp_q.push_back(e);
        m_done = 1'b1;
        m_cnt  = CW'(c);
        busy_cycles = 2 * n;
    endtask

    function automatic out_t halt_vec();
        out_t e;
        e = '0; e.done = 1'b1; e.cnt = m_cnt; e.operand = m_opnd;
        return e;
    endfunction

    // Called at #1 after a rising edge; returns at the same phase with the core halted.
    task automatic run_prog(input logic [AB-1:0] entry, input string name);
        int cyc;
        model_program(entry, 1 << 30, cyc);
        bus.start    = 1'b1;
        pc_force     = 1'b1;
        pc_force_val = entry;
        @(posedge clk); #1;
        pc_force = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check({name, "_halt_hold"}, 64'(sample()), 64'(halt_vec()));
    endtask

    logic prev_done = 1'b0;
    initial begin
        out_t act, exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
            end else begin
                act = sample();
                if (act.busy || act.wrpc || (act.done && !prev_done)) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_output", 64'(act), 64'(0));
                    end else begin
                        exp = exp_q.pop_front();
                        check("sb_cycle", 64'(act), 64'(exp));
                    end
                end
                prev_done = act.done;
            end
        end
    end

    initial begin
        int cyc;
        int n;
        bus.start = 1'b0;
        #1;
        check("reset_outputs", 64'(sample()), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_no_start", 64'(sample()), 64'(0));

        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0000;
        run_prog(11'h000, "ldi_addi_hlt");
        check("six_cycles", 64'(bus.clk_count), 64'(6));

        mem[0] = {5'd1, 11'h010}; mem[1] = {5'd6, 11'h010}; mem[2] = 16'h0000;
        run_prog(11'h000, "sto_sub");

        mem[0] = {5'd31, 11'h3A5}; mem[1] = {5'd31, 11'h000}; mem[2] = {5'd0, 11'h7FF};
        run_prog(11'h000, "nop_ignore_start");

        mem[11'h7FE] = {5'd3, 11'h001}; mem[11'h7FF] = {5'd5, 11'h002};
        mem[0] = {5'd31, 11'h055}; mem[1] = {5'd0, 11'h000};
        run_prog(11'h7FE, "pc_wrap");

        // Reset lands in the middle of an ADD execute cycle.
        mem[0] = {5'd4, 11'h123}; mem[1] = 16'h0000;
        model_program(11'h000, 2, cyc);
        bus.start = 1'b1; pc_force = 1'b1; pc_force_val = '0;
        @(posedge clk); #1;
        pc_force = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check("add_exec_strobes", 64'({bus.WrPC, bus.WrAcc, bus.RdRam}), 64'(3'b111));
        #1 rst_n = 1'b0;
        #1 check("async_reset_drop", 64'(sample()), 64'(0));
        m_done = 1'b0; m_cnt = '0; m_opnd = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'(sample()), 64'(0));

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n - 1; i++)
                mem[i] = {OPW'($urandom_range(1, 31)), AB'($urandom)};
            mem[n-1] = {OPW'(0), AB'($urandom)};
            run_prog(11'h000, "random_prog");
        end

        @(posedge clk); #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
